spi_regfile_peripheral: RTL and testbench
=========================================

# spi_regfile_peripheral

Parametrised SPI target that exposes a configurable bank of control registers to an external SPI controller. It supports writes and reads (read data driven on CIPO), so firmware can confirm register contents. It sits between the chip's `ui_in`/`uo_out` pins and the PWM/output-enable logic, replacing the fixed five-register, write-only peripheral. All SPI inputs are asynchronous to `clk` and are resynchronised internally.

## Interface
- `NUM_REGS`, 5: number of registers, 1..(2**ADDR_W).
- `ADDR_W`, 7: address field width in bits.
- `DATA_W`, 8: register and data field width in bits.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sclk` in 1: SPI clock, raw pin.
- `ncs` in 1: SPI chip select, active-low, raw pin.
- `copi` in 1: SPI controller-out data, raw pin.
- `cipo` out 1: SPI controller-in data.
- `cipo_oe` out 1: CIPO output enable, high only while a read data phase is active.
- `regs` out NUM_REGS*DATA_W: flattened register bank; register i is `regs[i*DATA_W +: DATA_W]`.
- `wr_stb` out NUM_REGS: one-`clk` pulse on bit i when register i is written.
- `frame_abort` out 1: one-`clk` pulse when `ncs` rises mid-word.

## Operation
- SPI mode 0, MSB first. `copi` is sampled on the synchronised `sclk` rising edge. `cipo` changes on the synchronised `sclk` falling edge.
- Frame layout: 1 R/W bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- FSM states:
  - IDLE: entered from any state on `ncs` high. Moves to CMD on the synchronised `ncs` falling edge; clears the bit counter.
  - CMD: shifts 1+ADDR_W bits, then moves to DATA. On a read, the addressed register (0 if out of range) loads the shift-out register at the CMD→DATA transition. Its MSB drives `cipo` and `cipo_oe` rises at the same time.
  - DATA: shifts DATA_W bits.
    - Write: when the last bit is sampled, an in-range address updates the register and pulses `wr_stb[addr]`. An out-of-range address is dropped silently; no strobe.
    - Read: `copi` is ignored.
    - Then moves to DONE, or re-enters DATA when burst is enabled (see Configuration).
  - DONE: ignores `sclk`, holds `cipo_oe` low, waits for `ncs` high.
- `ncs` rising in CMD or DATA: no write, `frame_abort` pulses, return to IDLE. `ncs` rising in DONE or IDLE: no pulse.
- `cipo` is 0 whenever `cipo_oe` is 0.
- Reset (any time, including mid-frame): all registers 0, `cipo` 0, `cipo_oe` 0, `wr_stb` 0, `frame_abort` 0, FSM IDLE, counters 0.

## Timing
- Input synchronisers: 2 flops, plus 1 flop for edge detection.
- `sclk` high and low times must each be ≥ 4 `clk` periods. Faster `sclk` is unsupported.
- Write latency: the register and `wr_stb` update on the 4th `clk` rising edge after the raw `sclk` rising edge of the last data bit.
- Read: `cipo` is valid ≤ 4 `clk` after the raw `sclk` falling edge, so it meets mode 0 setup at the next `sclk` rise given the minimum `sclk` period.
- `frame_abort` fires 3 `clk` after the raw `ncs` rise.
- If an `sclk` rise and an `ncs` rise are detected in the same cycle, the `ncs` rise wins and no write occurs.

## Configuration
- `SPI_BURST_EN` defined:
  - After each data word, if `ncs` stays low, the address increments. It wraps from NUM_REGS-1 to 0.
  - Another DATA_W-bit word follows with the same R/W direction.
  - Each read word is reloaded at the word boundary.
- Not defined: DATA always goes to DONE. Extra clocks are ignored and extra read bits return 0.

## Structure
- `spi_pkg`: FSM state enum (IDLE, CMD, DATA, DONE), R/W bit encoding constants, and a function computing the counter width from ADDR_W/DATA_W.
- Sub-module `spi_sync_edge`: a 2-flop synchroniser with rise/fall detect. Instanced for `sclk`, `ncs` and `copi` (fall/rise outputs unused for `copi`).

## Test plan
- Write 0xA5 to address 0x02 → `regs[2]` = 0xA5; `wr_stb` = 5'b00100 for one cycle; all other registers unchanged.
- Write 0x3C to 0x04, then read 0x04 → `cipo` shifts 0011_1100 MSB first; `cipo_oe` high for exactly 8 `sclk` periods.
- Write 0xFF to out-of-range address 0x05 → no register changes, `wr_stb` stays 0; reading 0x05 returns 0x00.
- Raise `ncs` after 12 of 16 bits of a write of 0x55 to 0x01 → `regs[1]` unchanged, `frame_abort` pulses once; the next full frame works normally.
- Assert `rst` mid-write after registers were preloaded → all `regs` 0 immediately; a fresh frame after release writes correctly.
- With `SPI_BURST_EN`, write 0x11, 0x22 starting at address 0x04 → `regs[4]` = 0x11, `regs[0]` = 0x22 (wrap).

Source files
------------

// File: rtl/spi_regfile_peripheral_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
// Burst transfers are enabled by defining SPI_BURST_EN.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } spi_state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // Bit counter must reach ADDR_W in CMD and DATA_W-1 in DATA.
   function automatic int cnt_width(input int addr_w, input int data_w);
      int max_v;
      max_v = (addr_w > data_w - 1) ? addr_w : data_w - 1;
      return (max_v < 1) ? 1 : $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an external controller and the register-file target.
interface spi_regfile_peripheral_if;
   logic sclk;
   logic ncs;
   logic copi;
   logic cipo;
   logic cipo_oe;

   modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
   modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus one history flop for edge detection.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchroniser chain and edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= RST_VAL;
         sync_r <= RST_VAL;
         prev_r <= RST_VAL;
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign level = sync_r;
   assign rise  = sync_r & ~prev_r;
   assign fall  = ~sync_r & prev_r;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target exposing NUM_REGS read/write registers; frame = R/W, address, data.
// Optional burst mode (auto-increment address, wrapping) when SPI_BURST_EN is defined.
module spi_regfile_peripheral #(
   parameter int NUM_REGS = 5,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   spi_regfile_peripheral_if.slave      spi,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic [NUM_REGS-1:0]          wr_stb,
   output logic                         frame_abort
);
   import spi_pkg::*;

   localparam int CNT_W = cnt_width(ADDR_W, DATA_W);

   logic sclk_rise_s, sclk_fall_s, sclk_lvl_s;
   logic ncs_rise_s, ncs_fall_s, ncs_lvl_s;
   logic copi_s;
   logic [1:0] unused_copi_edges;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(spi.sclk),
      .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
   );
   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .din(spi.ncs),
      .level(ncs_lvl_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .din(spi.copi),
      .level(copi_s), .rise(unused_copi_edges[0]), .fall(unused_copi_edges[1])
   );

   spi_state_e          state_r, state_nxt;
   logic [CNT_W-1:0]    cnt_r, cnt_nxt;
   logic [ADDR_W:0]     cmd_r, cmd_nxt;
   logic [ADDR_W-1:0]   addr_r, addr_nxt;
   logic                rw_r, rw_nxt;
   logic [DATA_W-1:0]   din_r, din_nxt;
   logic [DATA_W-1:0]   dout_r, dout_nxt;
   logic                cipo_r, cipo_nxt;
   logic                cipo_oe_r, cipo_oe_nxt;
   logic                abort_r, abort_nxt;
   logic                commit_r, commit_nxt;
   logic [ADDR_W-1:0]   commit_addr_r, commit_addr_nxt;
   logic [DATA_W-1:0]   commit_data_r, commit_data_nxt;

   logic [DATA_W-1:0]   regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] wr_stb_r;

   logic [ADDR_W:0]     cmd_full_s;
   logic [DATA_W-1:0]   din_full_s;
   logic [DATA_W-1:0]   dout_shift_s;
   logic [DATA_W-1:0]   rd_word_s;

   assign cmd_full_s   = (ADDR_W+1)'({cmd_r, copi_s});
   assign din_full_s   = DATA_W'({din_r, copi_s});
   assign dout_shift_s = DATA_W'({dout_r, 1'b0});

   // Out-of-range addresses read back as zero.
   function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a,
                                                 input logic [NUM_REGS*DATA_W-1:0] bank);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) w = bank[i*DATA_W +: DATA_W];
      end
      return w;
   endfunction

`ifdef SPI_BURST_EN
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(NUM_REGS-1)) return '0;
      else return a + ADDR_W'(1);
   endfunction
   logic [ADDR_W-1:0] burst_addr_s;
   assign burst_addr_s = next_addr(addr_r);
   assign rd_word_s    = (state_r == ST_DATA) ? rd_word(burst_addr_s, regs)
                                              : rd_word(cmd_full_s[ADDR_W-1:0], regs);
`else
   assign rd_word_s    = rd_word(cmd_full_s[ADDR_W-1:0], regs);
`endif

   // Next-state and datapath decode; an ncs rise outranks any sclk edge in the same cycle.
   always_comb begin
      state_nxt       = state_r;
      cnt_nxt         = cnt_r;
      cmd_nxt         = cmd_r;
      addr_nxt        = addr_r;
      rw_nxt          = rw_r;
      din_nxt         = din_r;
      dout_nxt        = dout_r;
      cipo_nxt        = cipo_r;
      cipo_oe_nxt     = cipo_oe_r;
      abort_nxt       = 1'b0;
      commit_nxt      = 1'b0;
      commit_addr_nxt = commit_addr_r;
      commit_data_nxt = commit_data_r;
      if (ncs_rise_s || ncs_lvl_s) begin
         abort_nxt   = ncs_rise_s && ((state_r == ST_CMD) || (state_r == ST_DATA));
         state_nxt   = ST_IDLE;
         cnt_nxt     = '0;
         cipo_nxt    = 1'b0;
         cipo_oe_nxt = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ncs_fall_s) begin
                  state_nxt = ST_CMD;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt   = '0;
               end
            end
            ST_CMD: begin
               if (sclk_rise_s) begin
                  cmd_nxt = cmd_full_s;
                  if (cnt_r == CNT_W'(ADDR_W)) begin
                     state_nxt = ST_DATA;
                     cnt_nxt   = '0;
                     rw_nxt    = cmd_full_s[ADDR_W];
                     addr_nxt  = cmd_full_s[ADDR_W-1:0];
                     if (cmd_full_s[ADDR_W] == RW_READ) begin
                        dout_nxt    = rd_word_s;
                        cipo_nxt    = rd_word_s[DATA_W-1];
                        cipo_oe_nxt = 1'b1;
                     end else begin
                        cipo_oe_nxt = 1'b0;
                     end
                  end else begin
                     cnt_nxt = cnt_r + CNT_W'(1);
                  end
               end else begin
                  cnt_nxt = cnt_r;
               end
            end
            ST_DATA: begin
               if (sclk_rise_s) begin
                  din_nxt = din_full_s;
                  if (cnt_r == CNT_W'(DATA_W-1)) begin
                     commit_nxt      = (rw_r == RW_WRITE);
                     commit_addr_nxt = addr_r;
                     commit_data_nxt = din_full_s;
                     cnt_nxt         = '0;
`ifdef SPI_BURST_EN
                     addr_nxt = burst_addr_s;
                     if (rw_r == RW_READ) begin
                        dout_nxt = rd_word_s;
                        cipo_nxt = rd_word_s[DATA_W-1];
                     end else begin
                        cipo_nxt = 1'b0;
                     end
`else
                     state_nxt   = ST_DONE;
                     cipo_nxt    = 1'b0;
                     cipo_oe_nxt = 1'b0;
`endif
                  end else begin
                     cnt_nxt = cnt_r + CNT_W'(1);
                  end
               end else if (sclk_fall_s && (cnt_r != '0) && (rw_r == RW_READ)) begin
                  // The first fall after CMD belongs to the last address bit; MSB is already out.
                  dout_nxt = dout_shift_s;
                  cipo_nxt = dout_shift_s[DATA_W-1];
               end else begin
                  dout_nxt = dout_r;
               end
            end
            ST_DONE: begin
               cipo_nxt    = 1'b0;
               cipo_oe_nxt = 1'b0;
            end
            default: begin
               state_nxt   = ST_IDLE;
               cnt_nxt     = '0;
               cipo_nxt    = 1'b0;
               cipo_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   // FSM state and shift datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         cnt_r         <= '0;
         cmd_r         <= '0;
         addr_r        <= '0;
         rw_r          <= RW_READ;
         din_r         <= '0;
         dout_r        <= '0;
         cipo_r        <= 1'b0;
         cipo_oe_r     <= 1'b0;
         abort_r       <= 1'b0;
         commit_r      <= 1'b0;
         commit_addr_r <= '0;
         commit_data_r <= '0;
      end else begin
         state_r       <= state_nxt;
         cnt_r         <= cnt_nxt;
         cmd_r         <= cmd_nxt;
         addr_r        <= addr_nxt;
         rw_r          <= rw_nxt;
         din_r         <= din_nxt;
         dout_r        <= dout_nxt;
         cipo_r        <= cipo_nxt;
         cipo_oe_r     <= cipo_oe_nxt;
         abort_r       <= abort_nxt;
         commit_r      <= commit_nxt;
         commit_addr_r <= commit_addr_nxt;
         commit_data_r <= commit_data_nxt;
      end
   end

   // Register bank update; out-of-range commits match no entry and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_r   <= '{default: '0};
         wr_stb_r <= '0;
      end else begin
         wr_stb_r <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_r && (commit_addr_r == ADDR_W'(i))) begin
               regs_r[i]   <= commit_data_r;
               wr_stb_r[i] <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs[g*DATA_W +: DATA_W] = regs_r[g];
   end

   assign wr_stb      = wr_stb_r;
   assign frame_abort = abort_r;
   assign spi.cipo    = cipo_r;
   assign spi.cipo_oe = cipo_oe_r;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench: vector table, randomized frames against a register-array model, reset and burst sequences.
module tb_spi_regfile_peripheral;
   localparam int NR = 5;
`ifdef SPI_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [NR*8-1:0] regs_w;
   logic [NR-1:0]   wr_stb_w;
   logic            abort_w;

   spi_regfile_peripheral_if spi_if();

   spi_regfile_peripheral #(.NUM_REGS(NR), .ADDR_W(7), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .spi(spi_if), .regs(regs_w),
      .wr_stb(wr_stb_w), .frame_abort(abort_w)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] model [NR];

   typedef struct {
      bit         rw;
      logic [6:0] addr;
      logic [7:0] d0;
      logic [7:0] d1;
      int         nbits;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic [NR*8-1:0] model_flat();
      logic [NR*8-1:0] f;
      for (int i = 0; i < NR; i++) f[i*8 +: 8] = model[i];
      return f;
   endfunction

   function automatic logic [7:0] mword(input logic [6:0] a);
      return (a < 7'(NR)) ? model[a] : 8'h00;
   endfunction

   function automatic logic [6:0] waddr(input logic [6:0] a, input int w);
      logic [6:0] r;
      r = a;
      for (int k = 0; k < w; k++) r = (r == 7'(NR-1)) ? 7'd0 : r + 7'd1;
      return r;
   endfunction

   // One SPI frame of nbits bits (R/W, addr, d0, d1 MSB first), checked bit by bit against the model.
   task automatic frame(input bit rw, input logic [6:0] addr, input logic [7:0] d0,
                        input logic [7:0] d1, input int nbits, output logic [7:0] rd);
      logic [23:0] stream;
      logic [6:0]  a;
      logic [7:0]  word;
      logic [NR-1:0] exp_stb;
      int w, b;
      bit active;
      stream = {rw, addr, d0, d1};
      rd = 8'h00;
      w = 0; b = 0; a = addr;
      spi_if.ncs = 1'b0;
      tick(6);
      for (int i = 0; i < nbits; i++) begin
         spi_if.copi = stream[23-i];
         tick(6);
         if (i >= 8) begin
            w = (i - 8) / 8;
            b = 7 - ((i - 8) % 8);
            a = BURST ? waddr(addr, w) : addr;
            active = BURST || (w == 0);
            if (!rw && active) begin
               word = mword(a);
               check("cipo_oe_data", spi_if.cipo_oe, 1);
               check("cipo_bit", spi_if.cipo, word[b]);
               if (w == 0) rd[b] = spi_if.cipo;
            end else begin
               check("cipo_oe_idle", spi_if.cipo_oe, 0);
               check("cipo_idle", spi_if.cipo, 0);
            end
         end else begin
            active = 1'b0;
            check("cipo_oe_cmd", spi_if.cipo_oe, 0);
         end
         spi_if.sclk = 1'b1;
         if (i >= 8 && b == 0 && rw && active) begin
            exp_stb = (a < 7'(NR)) ? (NR'(1) << a) : '0;
            tick(3);
            check("wr_stb_early", wr_stb_w, 0);
            check("regs_early", regs_w, model_flat());
            if (a < 7'(NR)) model[a] = (w == 0) ? d0 : d1;
            tick(1);
            check("wr_stb", wr_stb_w, exp_stb);
            check("regs_write", regs_w, model_flat());
            tick(1);
            check("wr_stb_clear", wr_stb_w, 0);
            tick(1);
         end else begin
            tick(6);
         end
         spi_if.sclk = 1'b0;
      end
      tick(6);
      spi_if.ncs = 1'b1;
      tick(2);
      check("abort_early", abort_w, 0);
      tick(1);
      check("frame_abort", abort_w, (BURST || nbits < 16) ? 1 : 0);
      tick(1);
      check("abort_clear", abort_w, 0);
      tick(4);
      check("cipo_oe_end", spi_if.cipo_oe, 0);
      check("regs_end", regs_w, model_flat());
   endtask

   logic [7:0] rd;

   initial begin
      rst = 1'b1;
      spi_if.sclk = 1'b0;
      spi_if.ncs  = 1'b1;
      spi_if.copi = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = 8'h00;
      tick(3);
      check("rst_regs", regs_w, 0);
      check("rst_wr_stb", wr_stb_w, 0);
      check("rst_cipo", spi_if.cipo, 0);
      check("rst_cipo_oe", spi_if.cipo_oe, 0);
      check("rst_abort", abort_w, 0);
      rst = 1'b0;
      tick(4);

      vecs[0]  = '{1'b1, 7'h02, 8'hA5, 8'h00, 16, 8'h00};
      vecs[1]  = '{1'b1, 7'h04, 8'h3C, 8'h00, 16, 8'h00};
      vecs[2]  = '{1'b0, 7'h04, 8'h00, 8'h00, 16, 8'h3C};
      vecs[3]  = '{1'b1, 7'h05, 8'hFF, 8'h00, 16, 8'h00};
      vecs[4]  = '{1'b0, 7'h05, 8'h00, 8'h00, 16, 8'h00};
      vecs[5]  = '{1'b1, 7'h01, 8'h55, 8'h00, 12, 8'h00};
      vecs[6]  = '{1'b0, 7'h01, 8'h00, 8'h00, 16, 8'h00};
      vecs[7]  = '{1'b1, 7'h01, 8'h55, 8'h00, 16, 8'h00};
      vecs[8]  = '{1'b0, 7'h01, 8'h00, 8'h00, 16, 8'h55};
      vecs[9]  = '{1'b0, 7'h02, 8'h00, 8'h00, 24, 8'hA5};
      vecs[10] = '{1'b1, 7'h7F, 8'h81, 8'h00, 16, 8'h00};
      vecs[11] = '{1'b0, 7'h00, 8'h00, 8'h00, 16, 8'h00};

      for (int k = 0; k < 12; k++) begin
         frame(vecs[k].rw, vecs[k].addr, vecs[k].d0, vecs[k].d1, vecs[k].nbits, rd);
         if (!vecs[k].rw) check("table_rd", rd, vecs[k].exp_rd);
      end
      check("regs2_after_table", regs_w[2*8 +: 8], 8'hA5);

      for (int k = 0; k < 30; k++) begin
         bit rw_v;
         logic [6:0] a_v;
         logic [7:0] d_v;
         int nb;
         rw_v = 1'($urandom_range(0, 1));
         a_v  = 7'($urandom_range(0, 7));
         d_v  = 8'($urandom);
         nb   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
         frame(rw_v, a_v, d_v, 8'h00, nb, rd);
         if (!rw_v && nb == 16) check("rand_rd", rd, mword(a_v));
      end

      // Reset mid-write after preloading registers.
      frame(1'b1, 7'h00, 8'h12, 8'h00, 16, rd);
      frame(1'b1, 7'h03, 8'h34, 8'h00, 16, rd);
      spi_if.ncs = 1'b0;
      tick(6);
      for (int i = 0; i < 10; i++) begin
         spi_if.copi = i[0];
         tick(6);
         spi_if.sclk = 1'b1;
         tick(6);
         spi_if.sclk = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("midrst_regs", regs_w, 0);
      check("midrst_wr_stb", wr_stb_w, 0);
      check("midrst_cipo_oe", spi_if.cipo_oe, 0);
      tick(2);
      spi_if.ncs  = 1'b1;
      spi_if.copi = 1'b0;
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = 8'h00;
      tick(4);
      check("postrst_abort", abort_w, 0);
      frame(1'b1, 7'h02, 8'h5A, 8'h00, 16, rd);
      check("postrst_reg2", regs_w[2*8 +: 8], 8'h5A);

`ifdef SPI_BURST_EN
      frame(1'b1, 7'h04, 8'h11, 8'h22, 24, rd);
      check("burst_reg4", regs_w[4*8 +: 8], 8'h11);
      check("burst_reg0", regs_w[0*8 +: 8], 8'h22);
      frame(1'b0, 7'h04, 8'h00, 8'h00, 24, rd);
      check("burst_rd0", rd, 8'h11);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
